// File: rtl/stream_qos_pkg.sv
// rtl/stream_qos_pkg.sv - shared state type and saturating credit arithmetic for stream_qos_shaper
package stream_qos_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } shaper_state_e;

    localparam int DEF_CREDIT_WIDTH = 8;
    localparam int DEF_BUCKET_DEPTH = 16;

    // Most negative value a signed credit register of this width can hold.
    function automatic int credit_lower(input int credit_width);
        return -(1 << (credit_width - 1));
    endfunction

    function automatic int sat_credit_add(input int credit, input int delta,
                                          input int upper, input int lower);
        int sum;
        sum = credit + delta;
        if (sum > upper) return upper;
        if (sum < lower) return lower;
        return sum;
    endfunction

endpackage

// File: rtl/stream_qos_bucket.sv
// rtl/stream_qos_bucket.sv - one stream's credit bucket, packet FSM and gating
// STREAM_QOS_DEMOTE_EN: never block; packets starting without credit get qos forced to 0.
module stream_qos_bucket
    import stream_qos_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS_WIDTH  = 4,
    parameter int CREDIT_WIDTH = DEF_CREDIT_WIDTH,
    parameter int BUCKET_DEPTH = DEF_BUCKET_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_tick,
    input  logic [CREDIT_WIDTH-2:0] i_refill,
    input  logic [T_DATA_WIDTH-1:0] i_s_data,
    input  logic [T_QOS_WIDTH-1:0]  i_s_qos,
    input  logic                    i_s_last,
    input  logic                    i_s_valid,
    output logic                    o_s_ready,
    output logic [T_DATA_WIDTH-1:0] o_m_data,
    output logic [T_QOS_WIDTH-1:0]  o_m_qos,
    output logic                    o_m_last,
    output logic                    o_m_valid,
    input  logic                    i_m_ready,
    output logic                    o_credit_empty
);

    localparam int CREDIT_MAX = BUCKET_DEPTH;
    localparam int CREDIT_MIN = credit_lower(CREDIT_WIDTH);

    shaper_state_e                  r_state;
    logic signed [CREDIT_WIDTH-1:0] r_credit;
    logic                           w_open;
    logic                           w_beat;
    logic                           w_credit_pos;
    int                             w_delta;

    assign w_credit_pos   = (r_credit > 0);
    assign o_credit_empty = !w_credit_pos;

    assign o_m_valid = i_s_valid & w_open;
    assign o_s_ready = i_m_ready & w_open;
    assign o_m_data  = i_s_data;
    assign o_m_last  = i_s_last;
    assign w_beat    = o_m_valid & i_m_ready;

    // Refill and beat are folded into one delta so saturation is applied once.
    assign w_delta = (i_tick ? int'({1'b0, i_refill}) : 0) - (w_beat ? 1 : 0);

`ifdef STREAM_QOS_DEMOTE_EN
    logic r_demoted;
    logic w_demote;

    assign w_open   = 1'b1;
    assign w_demote = (r_state == IDLE) ? !w_credit_pos : r_demoted;
    assign o_m_qos  = w_demote ? '0 : i_s_qos;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_demoted <= 1'b0;
        end else if (w_beat) begin
            r_demoted <= !i_s_last && w_demote;
        end
    end
`else
    assign w_open  = (r_state == PKT) || w_credit_pos;
    assign o_m_qos = i_s_qos;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_credit <= CREDIT_WIDTH'(CREDIT_MAX);
        end else begin
            r_credit <= CREDIT_WIDTH'(sat_credit_add(int'(r_credit), w_delta,
                                                     CREDIT_MAX, CREDIT_MIN));
            if (w_beat) begin
                r_state <= i_s_last ? IDLE : PKT;
            end
        end
    end

endmodule

// File: rtl/stream_qos_shaper.sv
// rtl/stream_qos_shaper.sv - per-stream token-bucket shaper: shared refill timer and bucket fan-out
// STREAM_QOS_DEMOTE_EN (in stream_qos_bucket) selects demotion instead of blocking.
module stream_qos_shaper
    import stream_qos_pkg::*;
#(
    parameter int T_DATA_WIDTH  = 8,
    parameter int T_QOS__WIDTH  = 4,
    parameter int STREAM_COUNT  = 2,
    parameter int CREDIT_WIDTH  = DEF_CREDIT_WIDTH,
    parameter int BUCKET_DEPTH  = DEF_BUCKET_DEPTH,
    parameter int REFILL_PERIOD = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [STREAM_COUNT-1:0][CREDIT_WIDTH-2:0] cfg_refill_in,
    input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_in,
    input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_in,
    input  logic [STREAM_COUNT-1:0]                   s_last_in,
    input  logic [STREAM_COUNT-1:0]                   s_valid_in,
    output logic [STREAM_COUNT-1:0]                   s_ready_out,
    output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_out,
    output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] m_qos_out,
    output logic [STREAM_COUNT-1:0]                   m_last_out,
    output logic [STREAM_COUNT-1:0]                   m_valid_out,
    input  logic [STREAM_COUNT-1:0]                   m_ready_in,
    output logic [STREAM_COUNT-1:0]                   credit_empty_out
);

    localparam int TICK_W = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_W'(REFILL_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < STREAM_COUNT; g++) begin : g_bucket
        stream_qos_bucket #(
            .T_DATA_WIDTH (T_DATA_WIDTH),
            .T_QOS_WIDTH  (T_QOS__WIDTH),
            .CREDIT_WIDTH (CREDIT_WIDTH),
            .BUCKET_DEPTH (BUCKET_DEPTH)
        ) u_bucket (
            .clk            (clk),
            .rst            (rst),
            .i_tick         (w_tick),
            .i_refill       (cfg_refill_in[g]),
            .i_s_data       (s_data_in[g]),
            .i_s_qos        (s_qos_in[g]),
            .i_s_last       (s_last_in[g]),
            .i_s_valid      (s_valid_in[g]),
            .o_s_ready      (s_ready_out[g]),
            .o_m_data       (m_data_out[g]),
            .o_m_qos        (m_qos_out[g]),
            .o_m_last       (m_last_out[g]),
            .o_m_valid      (m_valid_out[g]),
            .i_m_ready      (m_ready_in[g]),
            .o_credit_empty (credit_empty_out[g])
        );
    end

endmodule

// File: doc/stream_qos_shaper.md
# stream_qos_shaper

Per-stream token-bucket traffic shaper placed between the stream sources and `stream_arbiter_w_qos`. It holds off (or, optionally, demotes) sources that exceed a configured beat rate, so that a high-QoS stream cannot monopolise the arbiter. Admission is packet-atomic: once a packet's first beat is accepted, the packet always runs to `last`. The datapath passes through combinationally; only the gating decision is derived from registered state.

## Interface
- `T_DATA_WIDTH`, 8: data width per stream.
- `T_QOS__WIDTH`, 4: QoS width per stream.
- `STREAM_COUNT`, 2: number of streams.
- `CREDIT_WIDTH`, 8: signed credit counter width. Range is −2^(CREDIT_WIDTH−1) .. `BUCKET_DEPTH`.
- `BUCKET_DEPTH`, 16: maximum credit per stream; must be ≤ 2^(CREDIT_WIDTH−1)−1.
- `REFILL_PERIOD`, 8: cycles between refill ticks; must be ≥ 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_refill_in`  in  [STREAM_COUNT][CREDIT_WIDTH−1]  credits added per tick for each stream (unsigned).
- `s_data_in` / `s_qos_in` / `s_last_in` / `s_valid_in`  in  per stream  source side.
- `s_ready_out`  out  [STREAM_COUNT]  source-side ready.
- `m_data_out` / `m_qos_out` / `m_last_out` / `m_valid_out`  out  per stream  arbiter side.
- `m_ready_in`  in  [STREAM_COUNT]  arbiter-side ready.
- `credit_empty_out`  out  [STREAM_COUNT]  1 when credit[i] ≤ 0.

## Operation
- **Refill timer:** `tick_cnt` counts 0..REFILL_PERIOD−1 and wraps. `tick` = (tick_cnt == REFILL_PERIOD−1).
- **Per-stream credit:** signed register `credit[i]`.
  - Next value = saturate(credit + (tick ? cfg_refill_in[i] : 0) − (beat[i] ? 1 : 0)).
  - Saturation: upper bound `BUCKET_DEPTH`, lower bound −2^(CREDIT_WIDTH−1).
  - `beat[i]` = m_valid_out[i] & m_ready_in[i].
  - A refill and a decrement in the same cycle are applied together; saturation is applied once, to the sum.
- **Per-stream FSM:**
  - IDLE: `open[i]` = (credit[i] > 0). An accepted beat with last=0 moves to PKT. An accepted beat with last=1 stays in IDLE.
  - PKT: `open[i]` = 1. An accepted beat with last=1 moves to IDLE.
- **Gating (combinational):**
  - m_valid_out[i] = s_valid_in[i] & open[i].
  - s_ready_out[i] = m_ready_in[i] & open[i].
  - data, qos and last pass straight through.
- **Debt:** credit may go negative only while a packet is in progress. The next packet is blocked until refills bring credit above 0.
- **Independence:** streams do not interact. Each stream has its own bucket and FSM; the refill timer is shared.

## Timing
- Zero-latency datapath; no cycles are added to a beat.
- Credit and state updates become visible the cycle after the causing beat or tick.
- A tick that raises credit from ≤0 to >0 unblocks the stream on the following cycle.
- **Reset values:** tick_cnt=0, credit[i]=BUCKET_DEPTH, all FSMs IDLE, credit_empty_out=0. Outputs during reset follow the gating rule with these register values.
- The first tick occurs in cycle REFILL_PERIOD−1 after reset deasserts.
- **Reset mid-packet:** the packet is abandoned (FSM→IDLE, credit→full). The shaper does not generate a `last` beat.
- **Blocked source:** while `m_ready_in` is low, or a valid beat is blocked, there is no decrement and no state change.
- **Packet start at credit 1:** the first beat is admitted and the rest of the packet follows regardless of credit.
- **REFILL_PERIOD=1:** tick is asserted every cycle.

## Configuration
- Macro: `STREAM_QOS_DEMOTE_EN`.
- **Undefined (default behaviour):** out-of-credit streams are blocked, as described above.
- **Defined:** IDLE streams are never blocked; open[i]=1 always.
  - A packet that starts with credit ≤ 0 is demoted: m_qos_out[i]=0 for every beat, first through last.
  - A `demoted[i]` flag is set on the first accepted beat when last=0, and cleared on the last beat.
  - demote = IDLE ? (credit ≤ 0) : demoted[i].
  - Credit still decrements, saturating at the lower bound. `demoted[i]` resets to 0.

## Structure
- Package `stream_qos_pkg` holds:
  - the `shaper_state_e` enum (IDLE, PKT);
  - the saturating credit-add function;
  - localparams for the credit bounds.
- Sub-module `stream_qos_bucket` holds one stream's credit counter, FSM, demote flag and gating. It is instantiated STREAM_COUNT times in a generate loop.
- The top level holds only the shared refill timer and the port fan-out.

## Test plan
All cases use STREAM_COUNT=2, CREDIT_WIDTH=6, BUCKET_DEPTH=8, REFILL_PERIOD=4.
- **Exhaustion:** refill=0; stream0 sends single-beat packets continuously with ready=1 → exactly 8 beats pass, then m_valid_out[0]=0, s_ready_out[0]=0, credit_empty_out[0]=1. Stream1 is unaffected.
- **Debt:** credit=1, 4-beat packet → all 4 beats pass, credit=−3. With refill=2, the next packet is blocked until after the 2nd tick (credit=1), then admitted the following cycle.
- **Saturation:** refill=3, idle 20 cycles → credit stays 8. A tick coinciding with a beat at credit=8 leaves credit=8.
- **Backpressure:** m_ready_in[0]=0 with valid held for 10 cycles → credit and FSM unchanged, and data is held at the output.
- **Reset mid-packet:** assert rst after the 2nd beat of a 4-beat packet → next cycle FSM=IDLE, credit=8, tick_cnt=0. A new packet is admitted immediately.
- **Demote (`STREAM_QOS_DEMOTE_EN`):** exhaust stream0, then send a qos=2, 3-beat packet → all 3 beats pass with m_qos_out[0]=0. Stream1's qos=2 passes unchanged. After refills bring credit above 0, stream0's qos=2 passes unchanged.
